// File: rtl/uart_tx_core.sv
// uart_tx_core: parametrised UART transmitter with one-entry holding register.
// Frames: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  localparam int BW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0] BAUD_MAX = BW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BAUD_PRE = BW'(OVERSAMPLE - 2);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e               state_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_valid_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [BW-1:0]        baud_q;
  logic [3:0]           bit_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  logic accept;
  logic bit_end;
  logic load;
  logic par_d;

  always_comb begin
    accept  = tx_valid && !hold_valid_q;
    bit_end = (baud_q == BAUD_MAX);
    load    = hold_valid_q &&
              ((state_q == S_IDLE) ||
               ((state_q == S_STOP) && bit_end && (bit_q == STOP_LAST)));
    par_d   = (PARITY == 2) ? ~^hold_q : ^hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      baud_q       <= '0;
      bit_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        hold_q       <= tx_data;
        hold_valid_q <= 1'b1;
      end
      if (load) begin
        // Covers both the idle start and the back-to-back stop->start hop.
        shift_q      <= hold_q;
        par_q        <= par_d;
        hold_valid_q <= 1'b0;
        state_q      <= S_START;
        tx_q         <= 1'b0;
        busy_q       <= 1'b1;
        baud_q       <= '0;
        bit_q        <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          S_START: begin
            if (bit_end) begin
              state_q <= S_DATA;
              tx_q    <= shift_q[0];
              baud_q  <= '0;
              bit_q   <= '0;
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          S_DATA: begin
            if (bit_end) begin
              shift_q <= shift_q >> 1;
              baud_q  <= '0;
              if (bit_q == DATA_LAST) begin
                bit_q <= '0;
                if (PARITY != 0) begin
                  state_q <= S_PAR;
                  tx_q    <= par_q;
                end else begin
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
                end
              end else begin
                bit_q <= bit_q + 4'd1;
                tx_q  <= shift_q[1];
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          S_PAR: begin
            if (bit_end) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
              baud_q  <= '0;
              bit_q   <= '0;
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          S_STOP: begin
            if (bit_end) begin
              baud_q <= '0;
              if (bit_q == STOP_LAST) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                bit_q   <= '0;
              end else begin
                bit_q <= bit_q + 4'd1;
              end
            end else begin
              baud_q <= baud_q + 1'b1;
              done_q <= (bit_q == STOP_LAST) && (baud_q == BAUD_PRE);
            end
          end
          default: begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_ready = ~hold_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: scoreboard bench; words queued on acceptance,
// frames decoded off the tx line and compared against the queue.
module tb_uart_tx_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] da;
  logic       va, ra, busya, donea, txa;
  logic [6:0] dbv;
  logic       vb, rb, busyb, doneb, txb;
  logic [7:0] dc;
  logic       vc, rc, busyc, donec, txc;

  uart_tx_core u_a (
    .clk(clk), .rst_n(rst_n), .tx_data(da), .tx_valid(va),
    .tx_ready(ra), .busy(busya), .done(donea), .tx(txa)
  );

  uart_tx_core #(
    .OVERSAMPLE(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .tx_data(dbv), .tx_valid(vb),
    .tx_ready(rb), .busy(busyb), .done(doneb), .tx(txb)
  );

  uart_tx_core #(
    .PARITY(0)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .tx_data(dc), .tx_valid(vc),
    .tx_ready(rc), .busy(busyc), .done(donec), .tx(txc)
  );

  int   sel = 0;
  logic m_tx, m_busy, m_done, m_ready;

  always_comb begin
    m_tx    = txa;
    m_busy  = busya;
    m_done  = donea;
    m_ready = ra;
    if (sel == 1) begin
      m_tx    = txb;
      m_busy  = busyb;
      m_done  = doneb;
      m_ready = rb;
    end else if (sel == 2) begin
      m_tx    = txc;
      m_busy  = busyc;
      m_done  = donec;
      m_ready = rc;
    end
  end

  int         nchk = 0;
  int         nerr = 0;
  logic [8:0] exp_q[$];
  int         acc_cyc;
  int         f_start;
  int         f_end;

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [8:0] w, input logic v);
    case (sel)
      1: begin dbv = w[6:0]; vb = v; end
      2: begin dc = w[7:0]; vc = v; end
      default: begin da = w[7:0]; va = v; end
    endcase
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [8:0] w);
    bit ok;
    ok = 0;
    drive(w, 1'b1);
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (m_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    if (ok) begin
      exp_q.push_back(w);
      acc_cyc = cyc;
    end else begin
      check("send_timeout", 0, 1);
    end
    drive(w, 1'b0);
  endtask

  task automatic rx_frame(input int os, input int dbits, input int par,
                          input int sb, input string nm);
    int         nb, got, unstable, dones, done_at, busy_lo, idx, stops;
    logic       bits[16];
    logic [8:0] w, m;
    logic       p;
    bit         found;
    nb = 1 + dbits + ((par != 0) ? 1 : 0) + sb;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (m_tx == 1'b0) found = 1;
    end
    if (!found) begin
      check({nm, "_start_timeout"}, 0, 1);
      return;
    end
    f_start = cyc;
    unstable = 0;
    dones = 0;
    done_at = -1;
    busy_lo = 0;
    idx = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < os; c++) begin
        if (idx != 0) @(negedge clk);
        if (c == 0) bits[b] = m_tx;
        else if (m_tx !== bits[b]) unstable++;
        if (m_done) begin
          dones++;
          done_at = idx;
        end
        if (!m_busy) busy_lo++;
        idx++;
      end
    end
    f_end = cyc;
    if (exp_q.size() == 0) begin
      check({nm, "_unexpected_frame"}, 1, 0);
      return;
    end
    w = exp_q.pop_front();
    m = w & 9'((1 << dbits) - 1);
    p = (par == 2) ? ~^m : ^m;
    got = 0;
    for (int i = 0; i < dbits; i++) if (bits[1+i]) got |= (1 << i);
    stops = 0;
    for (int i = 0; i < sb; i++) if (bits[nb-1-i]) stops++;
    check({nm, "_start_bit"}, bits[0], 0);
    check({nm, "_data"}, got, int'(m));
    if (par != 0) check({nm, "_parity"}, bits[1+dbits], p);
    check({nm, "_stop_bits"}, stops, sb);
    check({nm, "_bit_stable"}, unstable, 0);
    check({nm, "_done_count"}, dones, 1);
    check({nm, "_done_pos"}, done_at, nb * os - 1);
    check({nm, "_busy_low"}, busy_lo, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, e1, nhi, nlow;
    rst_n = 1'b0;
    da = '0; va = 1'b0;
    dbv = '0; vb = 1'b0;
    dc = '0; vc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx", m_tx, 1);
    check("rst_busy", m_busy, 0);
    check("rst_ready", m_ready, 1);
    check("rst_done", m_done, 0);

    // Single default frame
    @(posedge clk); #1;
    fork
      send(9'hA5);
      rx_frame(16, 8, 1, 1, "a5");
    join
    @(negedge clk);
    check("a5_busy_end", m_busy, 0);
    check("a5_tx_idle", m_tx, 1);

    // Back-to-back, valid held high
    @(posedge clk); #1;
    fork
      begin
        send(9'h01);
        a1 = acc_cyc;
        send(9'hFF);
        check("b2b_accept_gap", acc_cyc - a1, 2);
      end
      begin
        rx_frame(16, 8, 1, 1, "b2b_1");
        e1 = f_end;
        rx_frame(16, 8, 1, 1, "b2b_2");
        check("b2b_line_gap", f_start - e1, 1);
      end
    join
    @(negedge clk);
    check("b2b_busy_end", m_busy, 0);

    // Hold register keeps queued word while tx_data changes
    @(posedge clk); #1;
    fork
      begin
        send(9'h11);
        repeat (20) @(posedge clk);
        #1;
        send(9'h3C);
        drive(9'h0C3, 1'b0);
        nhi = 0;
        repeat (100) begin
          @(negedge clk);
          if (m_ready) nhi++;
        end
        check("hold_ready_low", nhi, 0);
      end
      begin
        rx_frame(16, 8, 1, 1, "hold_1");
        rx_frame(16, 8, 1, 1, "hold_2");
      end
    join
    @(negedge clk);
    check("hold_busy_end", m_busy, 0);

    // OVERSAMPLE=4, 7 data bits, odd parity, 2 stops
    sel = 1;
    @(posedge clk); #1;
    fork
      send(9'h55);
      rx_frame(4, 7, 2, 2, "b55");
    join
    @(negedge clk);
    check("b55_busy_end", m_busy, 0);

    // No parity
    sel = 2;
    @(posedge clk); #1;
    fork
      send(9'h00);
      rx_frame(16, 8, 0, 1, "c00");
    join
    @(negedge clk);
    check("c00_busy_end", m_busy, 0);
    check("sb_empty", exp_q.size(), 0);

    // Reset mid-frame with a word held
    sel = 0;
    @(posedge clk); #1;
    send(9'h22);
    a1 = acc_cyc;
    send(9'h33);
    while (cyc < a1 + 50) begin
      @(posedge clk);
      #1;
    end
    check("rstm_pre_busy", m_busy, 1);
    check("rstm_pre_ready", m_ready, 0);
    check("rstm_pre_tx", m_tx, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_tx", m_tx, 1);
    check("rstm_busy", m_busy, 0);
    check("rstm_ready", m_ready, 1);
    check("rstm_done", m_done, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    nlow = 0;
    nhi = 0;
    repeat (500) begin
      @(negedge clk);
      if (!m_tx) nlow++;
      if (m_busy) nhi++;
    end
    check("rstm_quiet_tx", nlow, 0);
    check("rstm_quiet_busy", nhi, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
